// File: rtl/mipi_csi2_raw_pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mipi_csi2_pkg
//  Purpose  : Shared types, codes and CRC-16 helper for the CSI-2 pixel path.
//  Revision : 1.0  initial release
// ============================================================================
package mipi_csi2_pkg;

    localparam logic [5:0]  DT_RAW8  = 6'h2A;
    localparam logic [5:0]  DT_RAW10 = 6'h2B;

    localparam logic [15:0] CRC_POLY = 16'h8408;
    localparam logic [15:0] CRC_SEED = 16'hFFFF;

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_PIX   = 2'd1;
    localparam logic [1:0]  ST_PAD   = 2'd2;
    localparam logic [1:0]  ST_LSB   = 2'd3;

    typedef struct packed {
        logic [7:0] data;
        logic       sol;
        logic       eol;
    } byte_t;

    // Reflected CRC-16, one byte shifted in LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mipi_csi2_raw_pack_if.sv
`default_nettype none
// ============================================================================
//  Module   : mipi_csi2_raw_pack_if
//  Purpose  : Valid/ready stream with line markers (pixel or byte side).
//  Revision : 1.0  initial release
// ============================================================================
interface mipi_csi2_raw_pack_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         sol;
    logic         eol;

    modport master (output valid, data, sol, eol, input ready);
    modport slave  (input valid, data, sol, eol, output ready);
endinterface
`default_nettype wire

// File: rtl/mipi_csi2_raw_pack_crc16.sv
`default_nettype none
// ============================================================================
//  Module   : mipi_csi2_crc16
//  Purpose  : Byte-wide CRC-16 (0x8408 reflected) with seed-on-init.
//  Revision : 1.0  initial release
// ============================================================================
module mipi_csi2_crc16
    import mipi_csi2_pkg::*;
#(
    parameter logic [15:0] INIT = CRC_SEED
) (
    input  wire logic        pixclk,
    input  wire logic        reset,
    input  wire logic        crc_init_i,
    input  wire logic        crc_en_i,
    input  wire logic [7:0]  data_i,
    output logic      [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Init folds the seed into the same cycle as the first byte.
    always_comb begin
        crc_d = crc_q;
        if (crc_en_i) begin
            crc_d = crc16_byte(crc_init_i ? INIT : crc_q, data_i);
        end
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/mipi_csi2_raw_pack.sv
`default_nettype none
// ============================================================================
//  Module   : mipi_csi2_raw_pack
//  Purpose  : RAW8/RAW10 pixel stream to CSI-2 payload bytes with line CRC.
//  Revision : 1.0  initial release
// ============================================================================
module mipi_csi2_raw_pack
    import mipi_csi2_pkg::*;
#(
    parameter int          PIX_WIDTH = 10,
    parameter logic [15:0] CRC_INIT  = CRC_SEED
) (
    input  wire logic               pixclk,
    input  wire logic               reset,
    input  wire logic               enable,
    input  wire logic [3:0]         pixel_width,
    mipi_csi2_raw_pack_if.slave     pix_s,
    mipi_csi2_raw_pack_if.master    byte_m,
    output logic                    line_done,
    output logic      [15:0]        line_byte_cnt,
    output logic      [15:0]        line_crc,
    output logic                    err_sync,
    output logic                    err_width
);

    localparam logic [3:0] PW_RAW8  = 4'd8;
    localparam logic [3:0] PW_RAW10 = 4'd10;

    logic [1:0]           state_q, state_d;
    logic [1:0]           grp_q, grp_d;
    logic [7:0]           lsb_q, lsb_d;
    logic                 raw10_q, raw10_d;
    logic                 eol_pend_q, eol_pend_d;
    logic                 err_width_q, err_width_d;
    logic                 err_sync_q, err_sync_d;
    byte_t                obuf_q, obuf_d;
    logic                 ovalid_q, ovalid_d;
    logic                 line_done_q;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          line_cnt_q, line_crc_q;
    logic [15:0]          w_crc;

    logic [PIX_WIDTH-1:0] w_pix;
    logic                 w_slot_free, w_in_ready, w_accept, w_width_ok;
    logic                 w_start, w_take, w_raw10_cur, w_hs;
    logic [1:0]           w_grp_cur;

    assign w_pix       = pix_s.data;
    assign w_slot_free = !ovalid_q || byte_m.ready;
    assign w_in_ready  = !reset && enable && !err_width_q && w_slot_free
                         && (state_q == ST_IDLE || state_q == ST_PIX);
    assign w_accept    = pix_s.valid && w_in_ready;
    assign w_width_ok  = (pixel_width == PW_RAW8) || (pixel_width == PW_RAW10);
    assign w_start     = w_accept && pix_s.sol;
    // A pixel produces a byte if it opens a line with a legal width or continues one.
    assign w_take      = w_accept && (pix_s.sol ? w_width_ok : (state_q == ST_PIX));
    assign w_raw10_cur = w_start ? (pixel_width == PW_RAW10) : raw10_q;
    assign w_grp_cur   = w_start ? 2'd0 : grp_q;
    assign w_hs        = ovalid_q && byte_m.ready;

    always_ff @(posedge pixclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grp_q      <= 2'd0;
            lsb_q      <= 8'h00;
            raw10_q    <= 1'b0;
            eol_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grp_q      <= grp_d;
            lsb_q      <= lsb_d;
            raw10_q    <= raw10_d;
            eol_pend_q <= eol_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grp_d      = grp_q;
        lsb_d      = lsb_q;
        raw10_d    = raw10_q;
        eol_pend_d = eol_pend_q;
        if (w_start && !w_width_ok) begin
            state_d = ST_IDLE;
        end else if (w_take) begin
            raw10_d = w_raw10_cur;
            if (!w_raw10_cur) begin
                state_d    = pix_s.eol ? ST_IDLE : ST_PIX;
                grp_d      = 2'd0;
                eol_pend_d = 1'b0;
            end else begin
                // Slot 0 clears the group so padded slots contribute zero bits.
                case (w_grp_cur)
                    2'd0:    lsb_d      = {6'b000000, w_pix[1:0]};
                    2'd1:    lsb_d[3:2] = w_pix[1:0];
                    2'd2:    lsb_d[5:4] = w_pix[1:0];
                    default: lsb_d[7:6] = w_pix[1:0];
                endcase
                eol_pend_d = pix_s.eol;
                if (w_grp_cur == 2'd3) begin
                    state_d = ST_LSB;
                end else begin
                    state_d = pix_s.eol ? ST_PAD : ST_PIX;
                    grp_d   = w_grp_cur + 2'd1;
                end
            end
        end else if (state_q == ST_PAD && w_slot_free) begin
            if (grp_q == 2'd3) begin
                state_d = ST_LSB;
            end else begin
                grp_d = grp_q + 2'd1;
            end
        end else if (state_q == ST_LSB && w_slot_free) begin
            state_d = eol_pend_q ? ST_IDLE : ST_PIX;
            grp_d   = 2'd0;
        end
    end

    always_comb begin
        obuf_d      = obuf_q;
        ovalid_d    = ovalid_q;
        err_sync_d  = w_accept && (pix_s.sol ? (state_q != ST_IDLE) : (state_q == ST_IDLE));
        err_width_d = err_width_q || (w_start && !w_width_ok);
        cnt_d       = cnt_q;
        if (w_slot_free) begin
            ovalid_d = 1'b0;
            obuf_d   = '0;
            if (w_take) begin
                ovalid_d    = 1'b1;
                obuf_d.data = w_raw10_cur ? w_pix[9:2] : w_pix[7:0];
                obuf_d.sol  = pix_s.sol;
                obuf_d.eol  = !w_raw10_cur && pix_s.eol;
            end else if (state_q == ST_PAD) begin
                ovalid_d = 1'b1;
            end else if (state_q == ST_LSB) begin
                ovalid_d    = 1'b1;
                obuf_d.data = lsb_q;
                obuf_d.eol  = eol_pend_q;
            end
        end
        if (w_hs) begin
            cnt_d = obuf_q.sol ? 16'd1 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            obuf_q      <= '0;
            ovalid_q    <= 1'b0;
            err_sync_q  <= 1'b0;
            err_width_q <= 1'b0;
            cnt_q       <= 16'd0;
            line_done_q <= 1'b0;
            line_cnt_q  <= 16'd0;
            line_crc_q  <= 16'd0;
        end else begin
            obuf_q      <= obuf_d;
            ovalid_q    <= ovalid_d;
            err_sync_q  <= err_sync_d;
            err_width_q <= err_width_d;
            cnt_q       <= cnt_d;
            line_done_q <= w_hs && obuf_q.eol;
            // Running totals already include the eol byte during the line_done cycle.
            if (line_done_q) begin
                line_cnt_q <= cnt_q;
                line_crc_q <= w_crc;
            end
        end
    end

    mipi_csi2_crc16 #(
        .INIT       (CRC_INIT)
    ) u_crc (
        .pixclk     (pixclk),
        .reset      (reset),
        .crc_init_i (obuf_q.sol),
        .crc_en_i   (w_hs),
        .data_i     (obuf_q.data),
        .crc_o      (w_crc)
    );

    assign pix_s.ready   = w_in_ready;
    assign byte_m.valid  = ovalid_q;
    assign byte_m.data   = obuf_q.data;
    assign byte_m.sol    = obuf_q.sol;
    assign byte_m.eol    = obuf_q.eol;
    assign line_done     = line_done_q;
    assign line_byte_cnt = line_cnt_q;
    assign line_crc      = line_crc_q;
    assign err_sync      = err_sync_q;
    assign err_width     = err_width_q;

endmodule
`default_nettype wire

// File: tb/tb_mipi_csi2_raw_pack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mipi_csi2_raw_pack
//  Purpose  : Directed vector bench for the RAW8/RAW10 CSI-2 packer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mipi_csi2_raw_pack;

    logic        pixclk = 1'b0;
    logic        reset, enable;
    logic [3:0]  pixel_width;
    logic        line_done, err_sync, err_width;
    logic [15:0] line_byte_cnt, line_crc;

    mipi_csi2_raw_pack_if #(.W(10)) pix_if ();
    mipi_csi2_raw_pack_if #(.W(8))  byte_if ();

    mipi_csi2_raw_pack #(
        .PIX_WIDTH     (10),
        .CRC_INIT      (16'hFFFF)
    ) dut (
        .pixclk        (pixclk),
        .reset         (reset),
        .enable        (enable),
        .pixel_width   (pixel_width),
        .pix_s         (pix_if),
        .byte_m        (byte_if),
        .line_done     (line_done),
        .line_byte_cnt (line_byte_cnt),
        .line_crc      (line_crc),
        .err_sync      (err_sync),
        .err_width     (err_width)
    );

    always #5 pixclk = ~pixclk;

    typedef struct packed {
        logic [3:0]       width;
        logic [3:0]       npix;
        logic [9:0][9:0]  pix;
        logic [3:0]       nbyte;
        logic [11:0][7:0] bytes;
        logic [15:0]      crc;
        logic [2:0]       rdy_low;
    } vec_t;

    vec_t        vt [6];
    int          errors = 0, checks = 0;
    int          cyc = 0, ld_cnt = 0, ld_cyc = 0, eol_cyc = 0, es_cnt = 0;
    int          low_cnt = 0, stab_err = 0, stall_mode = 0;
    bit          low_en = 0, prev_stall = 0;
    logic [9:0]  prev_b;
    logic [9:0]  obq [$];
    logic [9:0]  expq [$];
    logic [9:0]  bigpix [640];

    always @(posedge pixclk) cyc <= cyc + 1;

    // Byte capture, event counters and hold-while-stalled watch.
    always @(negedge pixclk) begin
        if (!reset) begin
            if (byte_if.valid && byte_if.ready) begin
                obq.push_back({byte_if.sol, byte_if.eol, byte_if.data});
                if (byte_if.eol) eol_cyc = cyc;
            end
            if (line_done) begin ld_cnt++; ld_cyc = cyc; end
            if (err_sync) es_cnt++;
            if (low_en && !pix_if.ready) low_cnt++;
            if (prev_stall && (!byte_if.valid ||
                {byte_if.sol, byte_if.eol, byte_if.data} !== prev_b)) stab_err++;
            prev_stall = byte_if.valid && !byte_if.ready;
            prev_b     = {byte_if.sol, byte_if.eol, byte_if.data};
        end else begin
            prev_stall = 0;
        end
    end

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pixclk); #1;
    endtask

    task automatic push(input logic [9:0] d, input logic s, input logic e);
        bit acc;
        int t = 0;
        pix_if.valid = 1'b1; pix_if.data = d; pix_if.sol = s; pix_if.eol = e;
        forever begin
            if (stall_mode != 0) byte_if.ready = 1'($urandom_range(0, 1));
            #1 acc = pix_if.ready;
            @(posedge pixclk); #1;
            if (acc) break;
            t++;
            if (t > 400) begin
                checks++; errors++;
                $display("FAIL push_timeout: pixel %0h never accepted", d);
                break;
            end
        end
        pix_if.valid = 1'b0; pix_if.sol = 1'b0; pix_if.eol = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            if (stall_mode != 0) byte_if.ready = 1'($urandom_range(0, 1));
            step();
        end
        byte_if.ready = 1'b1;
        repeat (20) step();
    endtask

    task automatic clear_stats();
        obq.delete(); ld_cnt = 0; es_cnt = 0; low_cnt = 0;
    endtask

    task automatic cmp_queue(input string nm);
        chk({nm, "_nbytes"}, obq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < obq.size(); i++)
            chk($sformatf("%s_byte%0d", nm, i), obq[i], expq[i]);
    endtask

    task automatic run_vec(input int k);
        logic [15:0] crc;
        clear_stats();
        pixel_width = vt[k].width;
        low_en = 1;
        for (int i = 0; i < int'(vt[k].npix); i++)
            push(vt[k].pix[i], i == 0, i == int'(vt[k].npix) - 1);
        drain(0);
        low_en = 0;
        expq.delete();
        for (int i = 0; i < int'(vt[k].nbyte); i++)
            expq.push_back({i == 0, i == int'(vt[k].nbyte) - 1, vt[k].bytes[i]});
        cmp_queue($sformatf("vec%0d", k));
        chk($sformatf("vec%0d_line_done_cnt", k), ld_cnt, 1);
        chk($sformatf("vec%0d_line_done_lat", k), ld_cyc - eol_cyc, 1);
        chk($sformatf("vec%0d_line_byte_cnt", k), line_byte_cnt, int'(vt[k].nbyte));
        chk($sformatf("vec%0d_line_crc", k), line_crc, vt[k].crc);
        chk($sformatf("vec%0d_in_ready_low", k), low_cnt, vt[k].rdy_low);
        crc = 16'hFFFF;
        for (int i = 0; i < int'(vt[k].nbyte); i++) crc = crc_ref(crc, vt[k].bytes[i]);
        chk($sformatf("vec%0d_crc_model", k), line_crc, crc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] crc;
        reset = 1; enable = 1; pixel_width = 4'd10;
        pix_if.valid = 0; pix_if.data = '0; pix_if.sol = 0; pix_if.eol = 0;
        byte_if.ready = 1;
        repeat (3) step();
        chk("rst_in_ready", pix_if.ready, 0);
        chk("rst_out_valid", byte_if.valid, 0);
        chk("rst_out_data", byte_if.data, 0);
        chk("rst_out_flags", {byte_if.sol, byte_if.eol}, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_line_cnt", line_byte_cnt, 0);
        chk("rst_line_crc", line_crc, 0);
        chk("rst_errs", {err_sync, err_width}, 0);
        reset = 0;
        step();
        enable = 0; #1 chk("enable_low_ready", pix_if.ready, 0);
        enable = 1; #1 chk("idle_ready", pix_if.ready, 1);

        for (int k = 0; k < 6; k++) vt[k] = '0;
        vt[0].width = 4'd8; vt[0].npix = 4'd9; vt[0].nbyte = 4'd9; vt[0].crc = 16'h6F91;
        for (int i = 0; i < 9; i++) begin
            vt[0].pix[i]   = 10'(i + 'h31);
            vt[0].bytes[i] = 8'(i + 'h31);
        end
        vt[1].width = 4'd10; vt[1].npix = 4'd4; vt[1].nbyte = 4'd5; vt[1].rdy_low = 3'd1;
        vt[1].pix[0] = 10'h3FF; vt[1].pix[1] = 10'h000; vt[1].pix[2] = 10'h155; vt[1].pix[3] = 10'h2AA;
        vt[1].bytes[0] = 8'hFF; vt[1].bytes[1] = 8'h00; vt[1].bytes[2] = 8'h55;
        vt[1].bytes[3] = 8'hAA; vt[1].bytes[4] = 8'h93;
        vt[2].width = 4'd10; vt[2].npix = 4'd6; vt[2].nbyte = 4'd10; vt[2].rdy_low = 3'd4;
        vt[2].pix[0] = 10'h001; vt[2].pix[1] = 10'h002; vt[2].pix[2] = 10'h003;
        vt[2].pix[3] = 10'h3FC; vt[2].pix[4] = 10'h2A5; vt[2].pix[5] = 10'h15A;
        vt[2].bytes[0] = 8'h00; vt[2].bytes[1] = 8'h00; vt[2].bytes[2] = 8'h00;
        vt[2].bytes[3] = 8'hFF; vt[2].bytes[4] = 8'h39; vt[2].bytes[5] = 8'hA9;
        vt[2].bytes[6] = 8'h56; vt[2].bytes[7] = 8'h00; vt[2].bytes[8] = 8'h00;
        vt[2].bytes[9] = 8'h09;
        vt[3].width = 4'd8; vt[3].npix = 4'd1; vt[3].nbyte = 4'd1; vt[3].crc = 16'h0F87;
        vt[4].width = 4'd10; vt[4].npix = 4'd1; vt[4].nbyte = 4'd5; vt[4].rdy_low = 3'd4;
        vt[4].pix[0] = 10'h2FE;
        vt[4].bytes[0] = 8'hBF; vt[4].bytes[4] = 8'h02;
        vt[5].width = 4'd8; vt[5].npix = 4'd2; vt[5].nbyte = 4'd2;
        vt[5].pix[0] = 10'h3A5; vt[5].pix[1] = 10'h13C;
        vt[5].bytes[0] = 8'hA5; vt[5].bytes[1] = 8'h3C;
        for (int k = 1; k < 6; k++) begin
            if (k == 3) continue;
            crc = 16'hFFFF;
            for (int i = 0; i < int'(vt[k].nbyte); i++) crc = crc_ref(crc, vt[k].bytes[i]);
            vt[k].crc = crc;
        end

        for (int k = 0; k < 6; k++) run_vec(k);

        // 640-pixel RAW10 line under random output back-pressure.
        clear_stats(); stab_err = 0; pixel_width = 4'd10; stall_mode = 1;
        expq.delete();
        for (int i = 0; i < 640; i++) bigpix[i] = 10'($urandom_range(0, 1023));
        for (int g = 0; g < 160; g++) begin
            for (int j = 0; j < 4; j++)
                expq.push_back({g == 0 && j == 0, 1'b0, bigpix[4*g+j][9:2]});
            expq.push_back({1'b0, g == 159, bigpix[4*g+3][1:0], bigpix[4*g+2][1:0],
                            bigpix[4*g+1][1:0], bigpix[4*g][1:0]});
        end
        for (int i = 0; i < 640; i++) push(bigpix[i], i == 0, i == 639);
        drain(100);
        stall_mode = 0;
        cmp_queue("stall640");
        crc = 16'hFFFF;
        for (int i = 0; i < expq.size(); i++) crc = crc_ref(crc, expq[i][7:0]);
        chk("stall640_line_cnt", line_byte_cnt, 800);
        chk("stall640_line_crc", line_crc, crc);
        chk("stall640_line_done", ld_cnt, 1);
        chk("stall640_hold_stable", stab_err, 0);

        // in_sol arriving after pixel 2 restarts the line.
        clear_stats(); pixel_width = 4'd10;
        push(10'h100, 1, 0); push(10'h200, 0, 0);
        push(10'h0FF, 1, 0); push(10'h001, 0, 0); push(10'h3FE, 0, 0); push(10'h123, 0, 1);
        drain(0);
        expq.delete();
        expq.push_back({2'b10, 8'h40}); expq.push_back({2'b00, 8'h80});
        expq.push_back({2'b10, 8'h3F}); expq.push_back({2'b00, 8'h00});
        expq.push_back({2'b00, 8'hFF}); expq.push_back({2'b00, 8'h48});
        expq.push_back({2'b01, 8'hE7});
        cmp_queue("midsol");
        chk("midsol_err_sync", es_cnt, 1);
        chk("midsol_line_done", ld_cnt, 1);
        chk("midsol_line_cnt", line_byte_cnt, 5);

        // Pixel without in_sol while idle is dropped.
        clear_stats();
        push(10'h055, 0, 0);
        drain(0);
        chk("idle_nosol_err_sync", es_cnt, 1);
        chk("idle_nosol_bytes", obq.size(), 0);

        // Reset while padding a one-pixel RAW10 line.
        clear_stats(); pixel_width = 4'd10;
        push(10'h2FE, 1, 1);
        reset = 1;
        step();
        chk("padrst_out_valid", byte_if.valid, 0);
        chk("padrst_in_ready", pix_if.ready, 0);
        chk("padrst_line_cnt", line_byte_cnt, 0);
        chk("padrst_line_crc", line_crc, 0);
        chk("padrst_line_done", line_done, 0);
        reset = 0;
        step();
        chk("padrst_idle_ready", pix_if.ready, 1);
        run_vec(4);

        // Unsupported width locks the input until reset.
        clear_stats(); pixel_width = 4'd12;
        push(10'h0AA, 1, 0);
        pix_if.valid = 1; pix_if.sol = 1;
        repeat (3) step();
        chk("width12_err_width", err_width, 1);
        chk("width12_in_ready", pix_if.ready, 0);
        chk("width12_bytes", obq.size(), 0);
        pix_if.valid = 0; pix_if.sol = 0;
        reset = 1;
        step();
        reset = 0; pixel_width = 4'd10;
        step();
        chk("width12_cleared", err_width, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
